// File: rtl/pipeline_stream_source.sv
// Bounded incrementing-word source with valid/ready handshake and optional
// LFSR-driven bubble insertion for exercising downstream buffering.
//
// state | meaning
// IDLE  | waiting for start; outputs quiescent
// SEND  | presenting words; advances only on valid_out & ready_in
// DONE  | one-cycle done pulse, then back to IDLE
module pipeline_stream_source #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_words,
    input  logic [WIDTH-1:0] start_value,
    input  logic             throttle_en,
    input  logic             ready_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sent_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [WIDTH-1:0] DATA_ONE = 1;

    state_t           r_state;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_sent;
    logic [CNT_W-1:0] r_remaining;
    logic [7:0]       r_lfsr;

    logic             w_xfer;
    logic             w_raise;
    logic             w_fb;

    assign w_xfer  = r_valid & ready_in;
    assign w_raise = ~throttle_en | r_lfsr[0];
    // x^8+x^6+x^5+x^4+1; a nonzero seed never reaches the all-zero state
    assign w_fb    = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_sent      <= '0;
            r_remaining <= '0;
            r_lfsr      <= 8'h01;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sent      <= '0;
                        r_remaining <= num_words;
                        r_busy      <= 1'b1;
                        if (num_words == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= SEND;
                            r_data  <= start_value;
                            r_valid <= w_raise;
                        end
                    end
                end
                SEND: begin
                    r_lfsr <= {r_lfsr[6:0], w_fb};
                    if (w_xfer) begin
                        r_sent      <= r_sent + CNT_ONE;
                        r_remaining <= r_remaining - CNT_ONE;
                        if (r_remaining == CNT_ONE) begin
                            r_valid <= 1'b0;
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_data  <= r_data + DATA_ONE;
                            r_valid <= w_raise;
                        end
                    end else if (!r_valid) begin
                        // bubble: only ever raise valid here, never drop it
                        r_valid <= w_raise;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign valid_out  = r_valid;
    assign data_out   = r_data;
    assign busy       = r_busy;
    assign done       = r_done;
    assign sent_count = r_sent;

endmodule

// File: tb/tb_pipeline_stream_source.sv
// Self-checking bench for pipeline_stream_source: directed table, reset abort,
// and randomized traffic checked against an arithmetic sequence model.
module tb_pipeline_stream_source;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] num_words;
    logic [WIDTH-1:0] start_value;
    logic             throttle_en;
    logic             ready_in;
    logic             valid_out;
    logic [WIDTH-1:0] data_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sent_count;

    int tests = 0;
    int fails = 0;

    pipeline_stream_source #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_words   (num_words),
        .start_value (start_value),
        .throttle_en (throttle_en),
        .ready_in    (ready_in),
        .valid_out   (valid_out),
        .data_out    (data_out),
        .busy        (busy),
        .done        (done),
        .sent_count  (sent_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int num;
        int sv;
        int thr;
        int mode;      // 0 ready high, 1 toggle, 2 random, 3 stall twice on word 2
        int exp_last;  // -1 = no check
        int exp_cyc;   // cycles from start edge to done; -1 = no check
    } vec_t;

    // Drive one sequence and compare what downstream receives with the
    // expected arithmetic sequence start_value, start_value+1, ... mod 16.
    task automatic run_seq(input int num, input int sv, input int thr, input int mode,
                           input int exp_last, input int exp_cyc, input bit busy_start,
                           input string tag);
        int               cyc = 0;
        int               q[$];
        bit               done_seen = 0;
        bit               prev_valid = 0;
        bit               prev_xfer = 0;
        logic [WIDTH-1:0] prev_data = '0;
        int               proto_err = 0;
        int               bubbles = 0;
        int               bad = 0;
        int               stall = 0;
        int               budget = 40 * num + 60;

        @(negedge clk);
        start       = 1'b1;
        num_words   = CNT_W'(num);
        start_value = WIDTH'(sv);
        throttle_en = thr[0];
        ready_in    = 1'b1;
        while (!done_seen && cyc < budget) begin
            @(negedge clk);
            cyc++;
            start = busy_start && (cyc == 2);
            if (busy_start && cyc == 2) begin
                num_words   = 8'd9;
                start_value = 4'hA;
            end else begin
                num_words   = CNT_W'(num);
                start_value = WIDTH'(sv);
            end
            if (prev_valid && !prev_xfer && (!valid_out || data_out !== prev_data))
                proto_err++;
            if (done)
                done_seen = 1;
            else if (busy && !valid_out)
                bubbles++;
            case (mode)
                0: ready_in = 1'b1;
                1: ready_in = ~ready_in;
                2: ready_in = 1'($urandom_range(0, 1));
                default: begin
                    if (valid_out && data_out == 4'h2 && stall < 2) begin
                        ready_in = 1'b0;
                        stall++;
                    end else begin
                        ready_in = 1'b1;
                    end
                end
            endcase
            if (mode == 2 && thr != 0)
                throttle_en = 1'($urandom_range(0, 1));
            prev_xfer  = valid_out && ready_in;
            if (prev_xfer)
                q.push_back(int'(data_out));
            prev_valid = valid_out;
            prev_data  = data_out;
        end
        start = 1'b0;

        check({tag, " done_seen"}, 32'(done_seen), 32'd1);
        check({tag, " xfer_count"}, 32'(q.size()), 32'(num));
        foreach (q[i])
            if (q[i] != ((sv + i) % 16)) bad++;
        check({tag, " value_errors"}, 32'(bad), 32'd0);
        check({tag, " sent_count"}, 32'(sent_count), 32'(num));
        check({tag, " protocol_errors"}, 32'(proto_err), 32'd0);
        if (exp_cyc >= 0)
            check({tag, " cycles_to_done"}, 32'(cyc), 32'(exp_cyc));
        if (exp_last >= 0 && q.size() > 0)
            check({tag, " last_word"}, 32'(q[q.size()-1]), 32'(exp_last));
        if (mode == 1 && thr != 0)
            check({tag, " bubbles_present"}, 32'(bubbles > 0), 32'd1);
        @(negedge clk);
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);
        check({tag, " busy_after"}, 32'(busy), 32'd0);
        check({tag, " sent_hold"}, 32'(sent_count), 32'(num));
        throttle_en = 1'b0;
        ready_in    = 1'b1;
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{num: 4,   sv: 0,  thr: 0, mode: 0, exp_last: 3,  exp_cyc: 5};
        vecs[1] = '{num: 4,   sv: 0,  thr: 0, mode: 3, exp_last: 3,  exp_cyc: 7};
        vecs[2] = '{num: 4,   sv: 14, thr: 0, mode: 0, exp_last: 1,  exp_cyc: 5};
        vecs[3] = '{num: 0,   sv: 5,  thr: 0, mode: 0, exp_last: -1, exp_cyc: 1};
        vecs[4] = '{num: 16,  sv: 0,  thr: 1, mode: 1, exp_last: 15, exp_cyc: -1};
        vecs[5] = '{num: 1,   sv: 7,  thr: 0, mode: 0, exp_last: 7,  exp_cyc: 2};
        vecs[6] = '{num: 255, sv: 3,  thr: 0, mode: 0, exp_last: 1,  exp_cyc: 256};

        rst = 1'b1; start = 1'b0; num_words = '0; start_value = '0;
        throttle_en = 1'b0; ready_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset valid_out", 32'(valid_out), 32'd0);
        check("reset data_out", 32'(data_out), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset sent_count", 32'(sent_count), 32'd0);
        rst = 1'b0;

        foreach (vecs[i])
            run_seq(vecs[i].num, vecs[i].sv, vecs[i].thr, vecs[i].mode,
                    vecs[i].exp_last, vecs[i].exp_cyc, 1'b0, $sformatf("vec%0d", i));

        // Abort an 8-word sequence after two transfers.
        @(negedge clk);
        start = 1'b1; num_words = 8'd8; start_value = 4'h0; ready_in = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort sent_before", 32'(sent_count), 32'd2);
        check("abort data_before", 32'(data_out), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort valid_out", 32'(valid_out), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort sent_count", 32'(sent_count), 32'd0);
        check("abort data_out", 32'(data_out), 32'd0);

        run_seq(3, 9, 0, 0, 11, 4, 1'b1, "after_abort");

        for (int r = 0; r < 6; r++) begin
            int n  = int'($urandom_range(0, 40));
            int s  = int'($urandom_range(0, 15));
            int th = int'($urandom_range(0, 1));
            run_seq(n, s, th, 2, -1, -1, 1'b0, $sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
